// File: rtl/lsu_mem_port.sv
// Load/store responder between the multicycle control FSM and a 64-bit data memory.
// Sub-doubleword stores are read-modify-write, so the memory needs no byte enables.
module lsu_mem_port #(
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [63:0] addr,
    input  logic [63:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [63:0] rdata,
    output logic [63:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata
);

    typedef enum logic [2:0] {IDLE, CHECK, RD, WAIT, MERGE, WR, DONE} state_t;

    state_t      state, stateNext;
    logic        weQ;
    logic [2:0]  funct3Q;
    logic [63:0] addrQ, wdataQ, dataQ;
    logic [2:0]  latCnt;

    logic        unsupported, misaligned, badAccess, isSd, capture;
    logic [5:0]  laneShift;
    logic [63:0] laneData, loadData, laneMask, mergedData;

    logic        busyNext, doneNext, errNext, memRdNext, memWrNext;
    logic [63:0] rdataNext, memAddrNext, memWdataNext;

    // Decode of the latched request
    always_comb begin
        unsupported = weQ ? funct3Q[2] : (funct3Q == 3'b111);
        case (funct3Q[1:0])
            2'd1:    misaligned = addrQ[0];
            2'd2:    misaligned = |addrQ[1:0];
            2'd3:    misaligned = |addrQ[2:0];
            default: misaligned = 1'b0;
        endcase
        badAccess = unsupported | misaligned;
        isSd      = weQ && (funct3Q == 3'b011);
        capture   = (state == WAIT) && (latCnt == 3'd1);
        laneShift = {addrQ[2:0], 3'b000};
    end

    // Lane extraction for loads, lane replacement for stores
    always_comb begin
        laneData = mem_rdata >> laneShift;
        case (funct3Q)
            3'b000:  loadData = {{56{laneData[7]}},  laneData[7:0]};
            3'b001:  loadData = {{48{laneData[15]}}, laneData[15:0]};
            3'b010:  loadData = {{32{laneData[31]}}, laneData[31:0]};
            3'b100:  loadData = {56'd0, laneData[7:0]};
            3'b101:  loadData = {48'd0, laneData[15:0]};
            3'b110:  loadData = {32'd0, laneData[31:0]};
            default: loadData = mem_rdata;
        endcase
        case (funct3Q[1:0])
            2'd0:    laneMask = 64'h0000_0000_0000_00FF << laneShift;
            2'd1:    laneMask = 64'h0000_0000_0000_FFFF << laneShift;
            default: laneMask = 64'h0000_0000_FFFF_FFFF << laneShift;
        endcase
        mergedData = (dataQ & ~laneMask) | ((wdataQ << laneShift) & laneMask);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (req) stateNext = CHECK;
            CHECK:   stateNext = badAccess ? DONE : (isSd ? WR : RD);
            RD:      stateNext = WAIT;
            WAIT:    if (capture) stateNext = weQ ? MERGE : DONE;
            MERGE:   stateNext = WR;
            WR:      stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Outputs are registered, so they are derived from the state being entered
    always_comb begin
        busyNext     = (stateNext != IDLE);
        doneNext     = (stateNext == DONE);
        errNext      = (state == CHECK) && badAccess;
        memRdNext    = (stateNext == RD);
        memWrNext    = (stateNext == WR);
        memAddrNext  = mem_addr;
        if (state == CHECK && !badAccess) memAddrNext = {addrQ[63:3], 3'b000};
        memWdataNext = mem_wdata;
        if (stateNext == WR) memWdataNext = isSd ? wdataQ : mergedData;
        rdataNext    = rdata;
        if (capture && !weQ) rdataNext = loadData;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            rdata     <= 64'd0;
            mem_addr  <= 64'd0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_wdata <= 64'd0;
            weQ       <= 1'b0;
            funct3Q   <= 3'd0;
            addrQ     <= 64'd0;
            wdataQ    <= 64'd0;
            dataQ     <= 64'd0;
            latCnt    <= 3'd0;
        end else begin
            busy      <= busyNext;
            done      <= doneNext;
            err       <= errNext;
            rdata     <= rdataNext;
            mem_addr  <= memAddrNext;
            mem_rd    <= memRdNext;
            mem_wr    <= memWrNext;
            mem_wdata <= memWdataNext;
            if (state == IDLE && req) begin
                weQ     <= we;
                funct3Q <= funct3;
                addrQ   <= addr;
                wdataQ  <= wdata;
            end
            if (state == RD)        latCnt <= 3'(MEM_LAT);
            else if (state == WAIT) latCnt <= latCnt - 3'd1;
            if (capture) dataQ <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Scoreboard bench: two instances (MEM_LAT 1 and 3) receive identical requests;
// per-instance monitors compare every completed transaction against queued expectations.
module tb_lsu_mem_port;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, req, we, loadMem;
    logic [2:0]  funct3;
    logic [63:0] addr, wdata;
    logic        busy [2], done [2], err [2], mem_rd [2], mem_wr [2];
    logic [63:0] rdata [2], mem_addr [2], mem_wdata [2], mem_rdata [2];
    logic [63:0] mem [2][32];
    int          seenIdx [2];
    int          cyc = 0;
    int          passCnt = 0;
    int          totalCnt = 0;

    typedef struct {
        int          t;
        bit          hasRd;
        bit          hasWr;
        bit          isErr;
        logic [63:0] rdata;
        logic [63:0] dwAddr;
        logic [63:0] wrData;
    } txn_t;

    txn_t expQ[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input int lat, input string name, input logic [63:0] act, input logic [63:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL [L=%0d] %s: got %h expected %h", lat, name, act, exp);
    endtask

    for (genvar gi = 0; gi < 2; gi++) begin : gPort
        localparam int L = (gi == 0) ? 1 : 3;
        logic [63:0] pipe [L];
        int          idx = 0;
        int          rdN = 0, wrN = 0, rdCyc = 0, wrCyc = 0, expDone = 0;
        logic [63:0] rdAddr, wrAddr, wrData;
        txn_t        e;

        lsu_mem_port #(.MEM_LAT(L)) dut (
            .clk(clk), .rst(rst), .req(req), .we(we), .funct3(funct3),
            .addr(addr), .wdata(wdata), .busy(busy[gi]), .done(done[gi]),
            .err(err[gi]), .rdata(rdata[gi]), .mem_addr(mem_addr[gi]),
            .mem_rd(mem_rd[gi]), .mem_wr(mem_wr[gi]), .mem_wdata(mem_wdata[gi]),
            .mem_rdata(mem_rdata[gi])
        );

        // Memory model: fixed read latency, unread cycles return a poison pattern
        always @(posedge clk) begin
            if (loadMem) begin
                for (int k = 0; k < 32; k++) mem[gi][k] <= 64'd0;
                mem[gi][2] <= 64'h0123_4567_89AB_CDEF;
                mem[gi][3] <= 64'h5555_5555_5555_5555;
                mem[gi][4] <= 64'hFEDC_BA98_7654_3210;
            end else if (mem_wr[gi]) begin
                mem[gi][mem_addr[gi][7:3]] <= mem_wdata[gi];
            end
            pipe[0] <= mem_rd[gi] ? mem[gi][mem_addr[gi][7:3]] : 64'hDEAD_DEAD_DEAD_DEAD;
            for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
        end
        assign mem_rdata[gi] = pipe[L-1];
        assign seenIdx[gi]   = idx;

        always @(negedge clk) begin
            if (rst) begin
                rdN = 0;
                wrN = 0;
            end else begin
                if (mem_rd[gi] && mem_wr[gi]) chk(L, "rd_wr_exclusive", 64'd1, 64'd0);
                if (mem_rd[gi]) begin rdN++; rdCyc = cyc; rdAddr = mem_addr[gi]; end
                if (mem_wr[gi]) begin wrN++; wrCyc = cyc; wrAddr = mem_addr[gi]; wrData = mem_wdata[gi]; end
                if (done[gi]) begin
                    if (idx >= expQ.size()) begin
                        chk(L, "unexpected_done", 64'(idx), 64'(expQ.size() - 1));
                    end else begin
                        e = expQ[idx];
                        expDone = e.isErr ? e.t + 2 : (!e.hasRd ? e.t + 3 : (e.hasWr ? e.t + 5 + L : e.t + 3 + L));
                        $display("L=%0d txn %0d: done at cycle %0d err=%0b rdata=%h", L, idx, cyc, err[gi], rdata[gi]);
                        chk(L, "done_cycle", 64'(cyc), 64'(expDone));
                        chk(L, "err", 64'(err[gi]), 64'(e.isErr));
                        chk(L, "rdata", rdata[gi], e.rdata);
                        chk(L, "rd_count", 64'(rdN), 64'(e.hasRd));
                        chk(L, "wr_count", 64'(wrN), 64'(e.hasWr));
                        if (e.hasRd) begin
                            chk(L, "rd_cycle", 64'(rdCyc), 64'(e.t + 2));
                            chk(L, "rd_addr", rdAddr, e.dwAddr);
                        end
                        if (e.hasWr) begin
                            chk(L, "wr_cycle", 64'(wrCyc), 64'(e.hasRd ? e.t + 4 + L : e.t + 2));
                            chk(L, "wr_addr", wrAddr, e.dwAddr);
                            chk(L, "wr_data", wrData, e.wrData);
                        end
                    end
                    idx++;
                    rdN = 0;
                    wrN = 0;
                end
            end
        end
    end

    task automatic waitIdle();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!busy[0] && !busy[1]) return;
        end
        chk(0, "idle_timeout", 64'(busy[0] | busy[1]), 64'd0);
    endtask

    task automatic issue(input bit w, input logic [2:0] f3, input logic [63:0] a, input logic [63:0] wd,
                         input bit isErr, input bit hr, input bit hw, input logic [63:0] expRd,
                         input logic [63:0] expWr, input int hold);
        txn_t t;
        waitIdle();
        t.t = cyc; t.hasRd = hr; t.hasWr = hw; t.isErr = isErr;
        t.rdata = expRd; t.dwAddr = {a[63:3], 3'b000}; t.wrData = expWr;
        expQ.push_back(t);
        req = 1'b1; we = w; funct3 = f3; addr = a; wdata = wd;
        repeat (hold) @(negedge clk);
        req = 1'b0; we = ~w; funct3 = 3'b111; addr = 64'hFFFF_FFFF_FFFF_FFFF; wdata = 64'h0BAD_0BAD_0BAD_0BAD;
    endtask

    task automatic load(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] expRd);
        issue(1'b0, f3, a, 64'd0, 1'b0, 1'b1, 1'b0, expRd, 64'd0, 1);
    endtask

    task automatic store(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] wd,
                         input logic [63:0] curRd, input logic [63:0] expWr);
        issue(1'b1, f3, a, wd, 1'b0, (f3 != 3'b011), 1'b1, curRd, expWr, 1);
    endtask

    task automatic errTxn(input bit w, input logic [2:0] f3, input logic [63:0] a, input logic [63:0] curRd);
        issue(w, f3, a, 64'h1111_2222_3333_4444, 1'b1, 1'b0, 1'b0, curRd, 64'd0, 1);
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; we = 1'b0; funct3 = 3'd0; addr = 64'd0; wdata = 64'd0; loadMem = 1'b1;
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            chk(g, "reset_busy", 64'(busy[g]), 64'd0);
            chk(g, "reset_done", 64'(done[g]), 64'd0);
            chk(g, "reset_err", 64'(err[g]), 64'd0);
            chk(g, "reset_rdata", rdata[g], 64'd0);
            chk(g, "reset_mem_rd", 64'(mem_rd[g]), 64'd0);
            chk(g, "reset_mem_wr", 64'(mem_wr[g]), 64'd0);
            chk(g, "reset_mem_addr", mem_addr[g], 64'd0);
            chk(g, "reset_mem_wdata", mem_wdata[g], 64'd0);
        end
        @(negedge clk);
        loadMem = 1'b0; rst = 1'b0;

        load(3'b000, 64'h13, 64'hFFFF_FFFF_FFFF_FF89);
        load(3'b100, 64'h13, 64'h0000_0000_0000_0089);
        load(3'b001, 64'h12, 64'hFFFF_FFFF_FFFF_89AB);
        load(3'b101, 64'h16, 64'h0000_0000_0000_0123);
        load(3'b110, 64'h10, 64'h0000_0000_89AB_CDEF);
        load(3'b010, 64'h14, 64'h0000_0000_0123_4567);
        load(3'b010, 64'h10, 64'hFFFF_FFFF_89AB_CDEF);
        load(3'b011, 64'h10, 64'h0123_4567_89AB_CDEF);
        store(3'b001, 64'h16, 64'h1234_5678_9ABC_BEEF, 64'h0123_4567_89AB_CDEF, 64'hBEEF_4567_89AB_CDEF);
        load(3'b011, 64'h10, 64'hBEEF_4567_89AB_CDEF);
        store(3'b011, 64'h18, 64'hDEAD_BEEF_CAFE_F00D, 64'hBEEF_4567_89AB_CDEF, 64'hDEAD_BEEF_CAFE_F00D);
        load(3'b011, 64'h18, 64'hDEAD_BEEF_CAFE_F00D);
        errTxn(1'b0, 3'b010, 64'h12, 64'hDEAD_BEEF_CAFE_F00D);
        errTxn(1'b0, 3'b111, 64'h10, 64'hDEAD_BEEF_CAFE_F00D);
        errTxn(1'b1, 3'b100, 64'h10, 64'hDEAD_BEEF_CAFE_F00D);
        errTxn(1'b1, 3'b001, 64'h11, 64'hDEAD_BEEF_CAFE_F00D);
        errTxn(1'b1, 3'b011, 64'h1C, 64'hDEAD_BEEF_CAFE_F00D);
        errTxn(1'b0, 3'b011, 64'h14, 64'hDEAD_BEEF_CAFE_F00D);
        store(3'b010, 64'h24, 64'h0000_0000_AABB_CCDD, 64'hDEAD_BEEF_CAFE_F00D, 64'hAABB_CCDD_7654_3210);
        store(3'b000, 64'h21, 64'h0000_0000_0000_0077, 64'hDEAD_BEEF_CAFE_F00D, 64'hAABB_CCDD_7654_7710);
        load(3'b011, 64'h20, 64'hAABB_CCDD_7654_7710);

        // sb aborted by reset while waiting on memory
        waitIdle();
        req = 1'b1; we = 1'b1; funct3 = 3'b000; addr = 64'h10; wdata = 64'd0;
        @(negedge clk);
        req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        for (int g = 0; g < 2; g++) begin
            chk(g, "abort_busy", 64'(busy[g]), 64'd0);
            chk(g, "abort_done", 64'(done[g]), 64'd0);
            chk(g, "abort_mem_rd", 64'(mem_rd[g]), 64'd0);
            chk(g, "abort_mem_wr", 64'(mem_wr[g]), 64'd0);
            chk(g, "abort_rdata", rdata[g], 64'd0);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;

        load(3'b011, 64'h10, 64'hBEEF_4567_89AB_CDEF);
        errTxn(1'b0, 3'b010, 64'h12, 64'hBEEF_4567_89AB_CDEF);
        issue(1'b0, 3'b000, 64'h13, 64'd0, 1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FF89, 64'd0, 5);
        load(3'b001, 64'h16, 64'hFFFF_FFFF_FFFF_BEEF);

        for (int i = 0; i < 100; i++) begin
            if (seenIdx[0] >= expQ.size() && seenIdx[1] >= expQ.size()) break;
            @(negedge clk);
        end
        repeat (8) @(negedge clk);
        for (int g = 0; g < 2; g++) chk(g, "completed_txns", 64'(seenIdx[g]), 64'(expQ.size()));

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
